sha3_perm_sched: RTL and testbench

Sequencer for the shared Keccak-f[1600] round datapath in the SHA3 core. It takes rate-sized message blocks from the input buffer and clears the state once per message. For each block it issues one XOR-absorb strobe followed by ROUNDS single-cycle round strobes with the round index. After the last block it holds the digest-valid handshake. It sits between the padding/buffer logic and the state register/round-function datapath.

---
 rtl/sha3_perm_sched_if.sv | 33 +++
 rtl/sha3_perm_sched.sv | 106 ++++++++++
 tb/tb_sha3_perm_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_perm_sched_if.sv
// Handshake/strobe bundle between the Keccak permutation scheduler and its
// neighbours: message control, input block buffer, round datapath and digest consumer.
interface sha3_perm_sched_if #(
    parameter int IDX_W  = 5,
    parameter int BCNT_W = 16
);
    logic              start;
    logic              abort;
    logic              blk_valid;
    logic              blk_last;
    logic              blk_ready;
    logic              state_clr;
    logic              absorb_en;
    logic              round_en;
    logic [IDX_W-1:0]  round_idx;
    logic              digest_valid;
    logic              digest_ack;
    logic              busy;
    logic [BCNT_W-1:0] blk_cnt;

    // master: the scheduler itself
    modport master (
        input  start, abort, blk_valid, blk_last, digest_ack,
        output blk_ready, state_clr, absorb_en, round_en, round_idx,
               digest_valid, busy, blk_cnt
    );

    modport slave (
        output start, abort, blk_valid, blk_last, digest_ack,
        input  blk_ready, state_clr, absorb_en, round_en, round_idx,
               digest_valid, busy, blk_cnt
    );
endinterface

// File: rtl/sha3_perm_sched.sv
// Sequencer for the shared Keccak-f[1600] round datapath: clear, then per block
// one absorb strobe and ROUNDS round strobes, then hold digest-valid until acked.
module sha3_perm_sched #(
    parameter int ROUNDS = 24,
    parameter int IDX_W  = 5,
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    sha3_perm_sched_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, WAIT_BLK, ABSORB, ROUND, DONE
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_RND = IDX_W'(ROUNDS - 1);
    localparam logic [BCNT_W-1:0] CNT_MAX  = '1;

    state_t state;
    logic   last_q;

    // Outputs are loaded together with the next state so every strobe is a
    // registered decode of the state it belongs to. round_idx doubles as the
    // round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_q           <= 1'b0;
            bus.blk_ready    <= 1'b0;
            bus.state_clr    <= 1'b0;
            bus.absorb_en    <= 1'b0;
            bus.round_en     <= 1'b0;
            bus.round_idx    <= '0;
            bus.digest_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.blk_cnt      <= '0;
        end else begin
            bus.blk_ready    <= 1'b0;
            bus.state_clr    <= 1'b0;
            bus.absorb_en    <= 1'b0;
            bus.round_en     <= 1'b0;
            bus.digest_valid <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state         <= CLEAR;
                            bus.state_clr <= 1'b1;
                            bus.busy      <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state         <= WAIT_BLK;
                        bus.blk_ready <= 1'b1;
                        bus.blk_cnt   <= '0;
                    end
                    WAIT_BLK: begin
                        if (bus.blk_valid) begin
                            last_q        <= bus.blk_last;
                            state         <= ABSORB;
                            bus.absorb_en <= 1'b1;
                        end else begin
                            bus.blk_ready <= 1'b1;
                        end
                    end
                    ABSORB: begin
                        if (bus.blk_cnt != CNT_MAX)
                            bus.blk_cnt <= bus.blk_cnt + 1'b1;
                        bus.round_idx <= '0;
                        state         <= ROUND;
                        bus.round_en  <= 1'b1;
                    end
                    ROUND: begin
                        if (bus.round_idx == LAST_RND) begin
                            if (last_q) begin
                                state            <= DONE;
                                bus.digest_valid <= 1'b1;
                            end else begin
                                state         <= WAIT_BLK;
                                bus.blk_ready <= 1'b1;
                            end
                        end else begin
                            bus.round_idx <= bus.round_idx + 1'b1;
                            bus.round_en  <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (bus.digest_ack) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.digest_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sha3_perm_sched.sv
// Directed bench for sha3_perm_sched: a default instance plus a BCNT_W=2 instance
// driven by the same stimulus to exercise block-counter saturation.
module tb_sha3_perm_sched;
    localparam int ROUNDS = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0, abort = 1'b0, blk_valid = 1'b0, blk_last = 1'b0, digest_ack = 1'b0;

    sha3_perm_sched_if #(.IDX_W(5), .BCNT_W(16)) i1 ();
    sha3_perm_sched_if #(.IDX_W(5), .BCNT_W(2))  i2 ();

    assign i1.start = start;       assign i2.start = start;
    assign i1.abort = abort;       assign i2.abort = abort;
    assign i1.blk_valid = blk_valid; assign i2.blk_valid = blk_valid;
    assign i1.blk_last = blk_last; assign i2.blk_last = blk_last;
    assign i1.digest_ack = digest_ack; assign i2.digest_ack = digest_ack;

    sha3_perm_sched #(.ROUNDS(ROUNDS), .IDX_W(5), .BCNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(i1.master));
    sha3_perm_sched #(.ROUNDS(ROUNDS), .IDX_W(5), .BCNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(i2.master));

    int checks = 0, errors = 0;
    int n_clr = 0, n_abs = 0, n_rnd = 0, n_dv = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        n_clr += int'(i1.state_clr);
        n_abs += int'(i1.absorb_en);
        n_rnd += int'(i1.round_en);
        n_dv  += int'(i1.digest_valid);
        chk("onehot_strobes_1", 32'($onehot0({i1.state_clr, i1.absorb_en, i1.round_en, i1.blk_ready})), 1);
        chk("onehot_strobes_2", 32'($onehot0({i2.state_clr, i2.absorb_en, i2.round_en, i2.blk_ready})), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_blk_ready"},    32'(i1.blk_ready), 0);
        chk({tag, "_state_clr"},    32'(i1.state_clr), 0);
        chk({tag, "_absorb_en"},    32'(i1.absorb_en), 0);
        chk({tag, "_round_en"},     32'(i1.round_en), 0);
        chk({tag, "_digest_valid"}, 32'(i1.digest_valid), 0);
        chk({tag, "_busy"},         32'(i1.busy), 0);
        chk({tag, "_round_idx"},    32'(i1.round_idx), 0);
        chk({tag, "_blk_cnt"},      32'(i1.blk_cnt), 0);
        chk({tag, "_blk_cnt2"},     32'(i2.blk_cnt), 0);
    endtask

    // Entered in a WAIT_BLK cycle; handshakes one block and runs its rounds.
    task automatic do_block(input logic last);
        chk("blk_ready_wait", 32'(i1.blk_ready), 1);
        blk_valid = 1'b1;
        blk_last  = last;
        step();
        chk("absorb_en", 32'(i1.absorb_en), 1);
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        for (int r = 0; r < ROUNDS; r++) begin
            step();
            chk("round_en", 32'(i1.round_en), 1);
            chk("round_idx", 32'(i1.round_idx), r);
        end
        step();
        if (last) chk("digest_valid_after_last", 32'(i1.digest_valid), 1);
        else      chk("blk_ready_after_block", 32'(i1.blk_ready), 1);
    endtask

    initial begin
        // reset
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        // single block: cycle 0 now, blk_valid/blk_last held from here
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        step();                                 // cycle 1
        chk("idle_no_clr", 32'(i1.state_clr), 0);
        start = 1'b1;
        step();                                 // cycle 2
        start = 1'b0;
        chk("t1_state_clr", 32'(i1.state_clr), 1);
        chk("t1_busy", 32'(i1.busy), 1);
        step();                                 // cycle 3
        n_dv = 0;
        do_block(1'b1);                         // ends at cycle 29
        chk("t1_blk_cnt", 32'(i1.blk_cnt), 1);
        step();                                 // cycle 30
        chk("t1_dv_hold", 32'(i1.digest_valid), 1);
        step();                                 // cycle 31
        digest_ack = 1'b1;
        step();                                 // cycle 32
        digest_ack = 1'b0;
        chk("t1_busy_after_ack", 32'(i1.busy), 0);
        chk("t1_dv_after_ack", 32'(i1.digest_valid), 0);
        chk("t1_blk_cnt_final", 32'(i1.blk_cnt), 1);
        chk("t1_dv_cycles", 32'(n_dv), 3);

        // three blocks with a 5-cycle stall before the second
        n_clr = 0; n_abs = 0; n_rnd = 0; n_dv = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_state_clr", 32'(i1.state_clr), 1);
        step();
        chk("t2_blk_cnt_cleared", 32'(i1.blk_cnt), 0);
        do_block(1'b0);
        for (int s = 0; s < 5; s++) begin
            step();
            chk("t2_stall_ready", 32'(i1.blk_ready), 1);
            chk("t2_stall_no_absorb", 32'(i1.absorb_en), 0);
        end
        do_block(1'b0);
        chk("t2_no_early_dv", 32'(i1.digest_valid), 0);
        chk("t2_blk_cnt_2", 32'(i1.blk_cnt), 2);
        do_block(1'b1);
        chk("t2_absorb_pulses", 32'(n_abs), 3);
        chk("t2_round_cycles", 32'(n_rnd), 72);
        chk("t2_dv_once", 32'(n_dv), 1);
        chk("t2_blk_cnt_3", 32'(i1.blk_cnt), 3);
        digest_ack = 1'b1;
        step();
        digest_ack = 1'b0;
        chk("t2_idle", 32'(i1.busy), 0);

        // abort at round 10 of block 2
        n_dv = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        do_block(1'b0);
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        step();
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        for (int r = 0; r <= 10; r++) step();
        chk("t3_round_idx_10", 32'(i1.round_idx), 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_busy", 32'(i1.busy), 0);
        chk("t3_round_en", 32'(i1.round_en), 0);
        chk("t3_blk_cnt_held", 32'(i1.blk_cnt), 2);
        for (int s = 0; s < 3; s++) step();
        chk("t3_no_dv", 32'(n_dv), 0);
        chk("t3_blk_cnt_still", 32'(i1.blk_cnt), 2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_restart_clr", 32'(i1.state_clr), 1);
        step();
        chk("t3_restart_blk_cnt", 32'(i1.blk_cnt), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_wait", 32'(i1.busy), 0);

        // rst pulsed during ROUND
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int r = 0; r < 3; r++) step();
        chk("t4_in_round", 32'(i1.round_en), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("t4_rst");

        // start pulses in WAIT_BLK, ROUND and DONE are ignored
        n_clr = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_wait_ready", 32'(i1.blk_ready), 1);
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        step();
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_round1", 32'(i1.round_idx), 1);
        for (int r = 2; r < ROUNDS; r++) step();
        step();
        chk("t4_done", 32'(i1.digest_valid), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_done_hold", 32'(i1.digest_valid), 1);
        chk("t4_one_clr", 32'(n_clr), 1);

        // ack and start together in DONE
        digest_ack = 1'b1;
        start = 1'b1;
        step();
        digest_ack = 1'b0;
        start = 1'b0;
        chk("t5_idle", 32'(i1.busy), 0);
        chk("t5_no_clr", 32'(i1.state_clr), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_clr", 32'(i1.state_clr), 1);
        chk("t5_clr_count", 32'(n_clr), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // five blocks: narrow counter saturates at 3
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        do_block(1'b0);
        do_block(1'b0);
        do_block(1'b0);
        chk("t6_cnt2_at_3", 32'(i2.blk_cnt), 3);
        do_block(1'b0);
        chk("t6_cnt2_sat", 32'(i2.blk_cnt), 3);
        chk("t6_cnt1_4", 32'(i1.blk_cnt), 4);
        do_block(1'b1);
        chk("t6_cnt1_5", 32'(i1.blk_cnt), 5);
        chk("t6_cnt2_final", 32'(i2.blk_cnt), 3);
        chk("t6_dv2", 32'(i2.digest_valid), 1);
        digest_ack = 1'b1;
        step();
        digest_ack = 1'b0;
        chk("t6_idle2", 32'(i2.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
